fdiv_iter: RTL

- Iterative IEEE-754 single-precision divider, y = x1 / x2; the long-latency, exact-rounding counterpart to the pipelined reciprocal unit in the FPU.
- Uses a restoring radix-2 mantissa divider with a valid/ready handshake on both input and output.
- Sits beside the reciprocal unit in the FPU. The core issues exact divides here and uses the reciprocal path only for approximations.

---
 rtl/fdiv_iter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative IEEE-754 single divider (restoring radix-2).
// Exact RNE quotient y = x1 / x2 with valid/ready on input and output.
//
// Ports:
//   clk, rstn            clock (rising), async active-low reset
//   x1, x2               dividend / divisor, IEEE single
//   in_valid, in_ready   operand handshake (in_ready only in IDLE)
//   y, out_valid,        result handshake; y held until accepted
//   out_ready
//   flags                {div_by_zero, overflow, underflow},
//                        present only when FDIV_FLAGS_EN is defined
//
// Parameter BITS_PER_CYCLE (1 or 2): quotient bits retired per
// CALC cycle. Denormal inputs are flushed to zero; no denormal
// outputs are produced.
module fdiv_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FDIV_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    localparam int QBITS = 26;
    localparam int NCYC  = QBITS / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(NCYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]  state_q;
    logic        sign_q;
    logic [9:0]  exp_q;
    logic [23:0] dvs_q;
    logic [25:0] rem_q;
    logic [24:0] quo_q;
    logic [4:0]  cnt_q;
    logic        spec_q;
    logic [31:0] y_q;
`ifdef FDIV_FLAGS_EN
    logic [2:0]  flags_q;
`endif

    // ---------------- operand decode ----------------
    logic [7:0]  e1, e2;
    logic [22:0] f1, f2;
    logic        z1, z2, i1, i2, n1, n2;
    logic        sgn;
    logic [23:0] m1, m2;
    logic        m_lt;
    logic [25:0] dvd;
    logic [9:0]  exp_in;
    logic        is_spec;
    logic [31:0] spec_y;

    assign e1  = x1[30:23];
    assign e2  = x2[30:23];
    assign f1  = x1[22:0];
    assign f2  = x2[22:0];
    assign sgn = x1[31] ^ x2[31];

    // exp==0 covers both zero and flushed denormals
    assign z1 = (e1 == 8'h00);
    assign z2 = (e2 == 8'h00);
    assign i1 = (e1 == 8'hFF) && (f1 == 23'd0);
    assign i2 = (e2 == 8'hFF) && (f2 == 23'd0);
    assign n1 = (e1 == 8'hFF) && (f1 != 23'd0);
    assign n2 = (e2 == 8'hFF) && (f2 != 23'd0);

    assign m1   = {1'b1, f1};
    assign m2   = {1'b1, f2};
    assign m_lt = (m1 < m2);

    // Pre-shifting a smaller dividend keeps the quotient in [1,2)
    assign dvd = m_lt ? {1'b0, m1, 1'b0} : {2'b00, m1};

    assign exp_in = {2'b00, e1} - {2'b00, e2}
                  + 10'd127 - {9'd0, m_lt};

    always_comb begin
        is_spec = 1'b1;
        spec_y  = QNAN;
        if (n1 || n2 || (z1 && z2) || (i1 && i2)) begin
            spec_y = QNAN;
        end else if (z2 && !i1) begin
            spec_y = {sgn, 8'hFF, 23'd0};
        end else if (i1) begin
            spec_y = {sgn, 8'hFF, 23'd0};
        end else if (z1 || i2) begin
            spec_y = {sgn, 31'd0};
        end else begin
            is_spec = 1'b0;
            spec_y  = 32'd0;
        end
    end

`ifdef FDIV_FLAGS_EN
    logic spec_dbz;
    assign spec_dbz = z2 && !z1 && !i1 && !n1;
`endif

    // ---------------- restoring iteration ----------------
    logic [25:0] r_nx;
    logic [24:0] q_nx;

    // Hidden quotient bit falls off the top of quo_q, leaving
    // 23 fraction bits, guard and round after the last shift.
    always_comb begin
        r_nx = rem_q;
        q_nx = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_nx >= {2'b00, dvs_q}) begin
                r_nx = r_nx - {2'b00, dvs_q};
                q_nx = {q_nx[23:0], 1'b1};
            end else begin
                q_nx = {q_nx[23:0], 1'b0};
            end
            r_nx = {r_nx[24:0], 1'b0};
        end
    end

    // ---------------- round / normalise ----------------
    logic        sticky;
    logic        rnd_up;
    logic [23:0] frac_s;
    logic [9:0]  exp_r;
    logic        ovf, unf;
    logic [31:0] y_n;

    assign sticky = |rem_q;
    assign rnd_up = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
    assign frac_s = {1'b0, quo_q[24:2]} + {23'd0, rnd_up};

    // Carry-out of rounding: fraction wraps to 0, exponent + 1
    assign exp_r = exp_q + {9'd0, frac_s[23]};
    assign ovf   = ($signed(exp_r) >= 10'sd255);
    assign unf   = ($signed(exp_r) <= 10'sd0);

    always_comb begin
        if (ovf) begin
            y_n = {sign_q, 8'hFF, 23'd0};
        end else if (unf) begin
            y_n = {sign_q, 31'd0};
        end else begin
            y_n = {sign_q, exp_r[7:0], frac_s[22:0]};
        end
    end

    // ---------------- control ----------------
    // Specials load y at accept and pass through NORM, so their
    // result appears one edge later from the same output stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            spec_q  <= 1'b0;
            y_q     <= '0;
`ifdef FDIV_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q  <= sgn;
                        exp_q   <= exp_in;
                        dvs_q   <= m2;
                        rem_q   <= dvd;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        spec_q  <= is_spec;
`ifdef FDIV_FLAGS_EN
                        flags_q <= {spec_dbz, 2'b00};
`endif
                        if (is_spec) begin
                            y_q     <= spec_y;
                            state_q <= S_NORM;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= r_nx;
                    quo_q <= q_nx;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (!spec_q) begin
                        y_q     <= y_n;
`ifdef FDIV_FLAGS_EN
                        flags_q <= {1'b0, ovf, unf};
`endif
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign y         = y_q;
`ifdef FDIV_FLAGS_EN
    assign flags     = flags_q;
`endif

endmodule
